// File: rtl/upg_pkg.sv
// Shared types and constants for the UART boot loader.
// UPG_CHECKSUM_EN adds the per-segment checksum state to the parser enum.
package upg_pkg;

  localparam int UPG_ADR_W     = 15;
  localparam int UPG_MAX_WORDS = 16384;
  localparam logic [7:0] UPG_TGT_PROG = 8'h00;
  localparam logic [7:0] UPG_TGT_DATA = 8'h01;
  localparam int UPG_LAST_BIT  = 7;

`ifdef UPG_CHECKSUM_EN
  typedef enum logic [2:0] {S_TGT, S_CNT_L, S_CNT_H, S_DATA, S_CSUM, S_DONE} upg_state_e;
`else
  typedef enum logic [2:0] {S_TGT, S_CNT_L, S_CNT_H, S_DATA, S_DONE} upg_state_e;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef struct packed {
    rx_state_e  rx;
    upg_state_e parser;
  } upg_dbg_t;

  // Only the low seven bits select the target; bit 7 is the last-segment flag.
  function automatic logic tgt_legal(input logic [6:0] code);
    return (code == UPG_TGT_PROG[6:0]) || (code == UPG_TGT_DATA[6:0]);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchroniser, mid-bit sampling, framing check.
// byte_vld_o / frm_err_o are single-cycle pulses with no back-pressure.
import upg_pkg::*;

module uart_byte_rx #(
  parameter int BIT_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frm_err_o,
  output rx_state_e  state_o
);

  localparam int HALF  = (BIT_DIV / 2 > 0) ? BIT_DIV / 2 : 1;
  localparam int CNT_W = $clog2(BIT_DIV + 1);

  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_tick;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_vld, r_ferr;
  logic             w_fall, w_hit, w_vld_nxt, w_ferr_nxt;

  // r_rx_s3 only serves edge detection; the synchronised level is r_rx_s2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_s3 & ~r_rx_s2;
  assign w_hit  = (r_state == RX_START) ? (r_tick == CNT_W'(HALF - 1))
                                        : (r_tick == CNT_W'(BIT_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RX_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      RX_START: if (w_hit)  w_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_hit && r_bit == 3'd7) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_hit)  w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_vld_nxt  = (r_state == RX_STOP) && w_hit &&  r_rx_s2;
    w_ferr_nxt = (r_state == RX_STOP) && w_hit && !r_rx_s2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_vld  <= w_vld_nxt;
      r_ferr <= w_ferr_nxt;
      if (r_state == RX_IDLE || w_hit) r_tick <= '0;
      else                             r_tick <= r_tick + 1'b1;
      if (r_state == RX_START && w_hit) r_bit <= '0;
      if (r_state == RX_DATA && w_hit) begin
        r_shift <= {r_rx_s2, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  assign byte_o     = r_shift;
  assign byte_vld_o = r_vld;
  assign frm_err_o  = r_ferr;
  assign state_o    = r_state;

endmodule

// File: rtl/uart_programmer.sv
// UART boot loader: parses TGT/CNT headers and little-endian words into write strobes.
// Define UPG_CHECKSUM_EN to require a trailing two's-complement checksum per segment.
import upg_pkg::*;

module uart_programmer #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int TIMEOUT_CYC = 16 * (CLK_FREQ / BAUD) * 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 upg_clk_o,
  output logic                 upg_wen_o,
  output logic [UPG_ADR_W-1:0] upg_adr_o,
  output logic [31:0]          upg_dat_o,
  output logic                 upg_done_o,
  output logic                 err_o,
  output upg_dbg_t             o_dbg_state
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]           w_byte;
  logic                 w_byte_vld, w_frm_err, w_vld, w_ferr;
  rx_state_e            w_rx_state;
  upg_state_e           r_state, w_state_nxt;
  logic                 r_tgt, r_last;
  logic [15:0]          r_cnt;
  logic [14:0]          r_idx;
  logic [1:0]           r_lane;
  logic [23:0]          r_word;
  logic                 r_wen, r_done, r_err;
  logic [UPG_ADR_W-1:0] r_adr;
  logic [31:0]          r_dat;
  logic [TMO_W-1:0]     r_tmo;
  logic [15:0]          w_n;
  logic                 w_last_word, w_timeout, w_seg_end, w_err_set;
  logic                 w_wen_nxt, w_tmo_run, w_done_nxt;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]           r_sum;
  logic [7:0]           w_sum_nxt;
  assign w_sum_nxt = r_sum + w_byte;
`endif

  uart_byte_rx #(.BIT_DIV(BIT_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_o     (w_byte),
    .byte_vld_o (w_byte_vld),
    .frm_err_o  (w_frm_err),
    .state_o    (w_rx_state)
  );

  // Once programming is done the serial line is ignored entirely.
  assign w_vld       = w_byte_vld && (r_state != S_DONE);
  assign w_ferr      = w_frm_err  && (r_state != S_DONE);
  assign w_n         = {w_byte, r_cnt[7:0]};
  assign w_last_word = ({1'b0, r_idx} + 16'd1) == r_cnt;
  assign w_timeout   = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_TGT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_seg_end   = 1'b0;
    case (r_state)
      S_TGT: if (w_vld) begin
        if (tgt_legal(w_byte[6:0])) w_state_nxt = S_CNT_L;
        else                        w_err_set   = 1'b1;
      end
      S_CNT_L: if (w_vld) w_state_nxt = S_CNT_H;
      S_CNT_H: if (w_vld) begin
        if (w_n > 16'(UPG_MAX_WORDS)) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_TGT;
        end else if (w_n == 16'd0) begin
          w_seg_end   = 1'b1;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: if (w_vld && r_lane == 2'd3 && w_last_word) w_seg_end = 1'b1;
`ifdef UPG_CHECKSUM_EN
      S_CSUM: if (w_vld) begin
        if (w_sum_nxt == 8'h00) begin
          w_state_nxt = r_last ? S_DONE : S_TGT;
        end else begin
          w_err_set   = 1'b1;
          w_state_nxt = S_TGT;
        end
      end
`endif
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_TGT;
    endcase
    if (w_seg_end) begin
`ifdef UPG_CHECKSUM_EN
      w_state_nxt = S_CSUM;
`else
      w_state_nxt = r_last ? S_DONE : S_TGT;
`endif
    end
    if (w_tmo_run && w_timeout && !w_vld) begin
      w_err_set   = 1'b1;
      w_state_nxt = S_TGT;
    end
    if (w_ferr) w_err_set = 1'b1;
  end

  always_comb begin
    w_tmo_run  = (r_state != S_TGT) && (r_state != S_DONE);
    w_wen_nxt  = w_vld && (r_state == S_DATA) && (r_lane == 2'd3);
    w_done_nxt = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tgt  <= 1'b0;
      r_last <= 1'b0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_lane <= '0;
      r_word <= '0;
      r_wen  <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_tmo  <= '0;
    end else begin
      r_wen  <= w_wen_nxt;
      r_done <= r_done | w_done_nxt;
      r_err  <= r_err | w_err_set;
      if (!w_tmo_run || w_vld) r_tmo <= '0;
      else if (!w_timeout)     r_tmo <= r_tmo + 1'b1;
      // The index advances on the edge that ends the strobe cycle.
      if (r_wen) r_idx <= r_idx + 1'b1;
      if (w_vld) begin
        case (r_state)
          S_TGT: begin
            r_tgt  <= w_byte[0];
            r_last <= w_byte[UPG_LAST_BIT];
          end
          S_CNT_L: r_cnt[7:0] <= w_byte;
          S_CNT_H: begin
            r_cnt[15:8] <= w_byte;
            r_idx       <= '0;
            r_lane      <= '0;
          end
          S_DATA: begin
            r_lane <= r_lane + 1'b1;
            case (r_lane)
              2'd0:    r_word[7:0]   <= w_byte;
              2'd1:    r_word[15:8]  <= w_byte;
              2'd2:    r_word[23:16] <= w_byte;
              default: begin
                r_adr <= {r_tgt, r_idx[13:0]};
                r_dat <= {w_byte, r_word};
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UPG_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_vld) begin
      if (r_state == S_TGT) r_sum <= w_byte;
      else if (r_state != S_CSUM) r_sum <= w_sum_nxt;
    end
  end
`endif

  assign upg_clk_o          = clk;
  assign upg_wen_o          = r_wen;
  assign upg_adr_o          = r_adr;
  assign upg_dat_o          = r_dat;
  assign upg_done_o         = r_done;
  assign err_o              = r_err;
  assign o_dbg_state.rx     = w_rx_state;
  assign o_dbg_state.parser = r_state;

endmodule

// File: tb/tb_uart_programmer.sv
// Directed bench for uart_programmer: serial segments in, write strobes checked against a queue.
module tb_uart_programmer;
  import upg_pkg::*;

  localparam int CLK_FREQ    = 1_600_000;
  localparam int BAUD        = 100_000;
  localparam int BIT_DIV     = 16;
  localparam int TIMEOUT_CYC = 16 * BIT_DIV * 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        upg_clk_o, upg_wen_o, upg_done_o, err_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  upg_dbg_t    o_dbg_state;

  uart_programmer #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .upg_clk_o   (upg_clk_o),
    .upg_wen_o   (upg_wen_o),
    .upg_adr_o   (upg_adr_o),
    .upg_dat_o   (upg_dat_o),
    .upg_done_o  (upg_done_o),
    .err_o       (err_o),
    .o_dbg_state (o_dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          wen_cyc  = -1;
  int          done_cyc = -1;
  logic [46:0] exp_q[$];
  logic [46:0] obs_q[$];
  logic [7:0]  tb_sum;

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (upg_wen_o === 1'b1) begin
      obs_q.push_back({upg_adr_o, upg_dat_o});
      wen_cyc = cyc;
    end
    if (upg_done_o === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    wen_cyc  = -1;
    done_cyc = -1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // drivers
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b);
    tb_sum = tb_sum + b;
    send_byte(b, 1'b1);
  endtask

  task automatic seg_begin(input logic [7:0] tgt, input logic [15:0] n);
    tb_sum = 8'h00;
    put_byte(tgt);
    put_byte(n[7:0]);
    put_byte(n[15:8]);
  endtask

  task automatic put_word(input logic [31:0] w);
    put_byte(w[7:0]);
    put_byte(w[15:8]);
    put_byte(w[23:16]);
    put_byte(w[31:24]);
  endtask

  task automatic seg_end();
`ifdef UPG_CHECKSUM_EN
    send_byte(8'h00 - tb_sum, 1'b1);
`endif
    repeat (40) @(negedge clk);
  endtask

  // scoreboard drain
  task automatic check_strobes(input string tag);
    logic [46:0] e, o;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else                  o = 'x;
      check(tag, {17'd0, o}, {17'd0, e});
    end
    obs_q.delete();
  endtask

  initial begin
    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wen",   64'(upg_wen_o),  64'd0);
    check("rst_adr",   64'(upg_adr_o),  64'd0);
    check("rst_dat",   64'(upg_dat_o),  64'd0);
    check("rst_done",  64'(upg_done_o), 64'd0);
    check("rst_err",   64'(err_o),      64'd0);
    check("rst_state", 64'(o_dbg_state.parser), 64'(S_TGT));
    do_reset();

    // A: single last segment, two words
    exp_q.push_back({15'h0000, 32'h00000013});
    exp_q.push_back({15'h0001, 32'hDEADBEEF});
    seg_begin(8'h80, 16'd2);
    put_word(32'h00000013);
    put_word(32'hDEADBEEF);
    seg_end();
    check_strobes("a_strobe");
    check("a_done", 64'(upg_done_o), 64'd1);
    check("a_err",  64'(err_o),      64'd0);
`ifndef UPG_CHECKSUM_EN
    check("a_done_lat", 64'(done_cyc - wen_cyc), 64'd1);
`endif
    // rx ignored after done
    seg_begin(8'h00, 16'd1);
    put_word(32'hCAFEF00D);
    seg_end();
    check_strobes("a_after_done");
    check("a_state_done", 64'(o_dbg_state.parser), 64'(S_DONE));
    // asynchronous reset clears outputs before any clock edge
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_done", 64'(upg_done_o), 64'd0);
    check("async_adr",  64'(upg_adr_o),  64'd0);
    check("async_dat",  64'(upg_dat_o),  64'd0);
    do_reset();

    // B: program segment then last data segment
    exp_q.push_back({15'h0000, 32'h11223344});
    exp_q.push_back({15'h4000, 32'h55667788});
    seg_begin(8'h00, 16'd1);
    put_word(32'h11223344);
    seg_end();
    check("b_done_early", 64'(upg_done_o), 64'd0);
    seg_begin(8'h81, 16'd1);
    put_word(32'h55667788);
    seg_end();
    check_strobes("b_strobe");
    check("b_done", 64'(upg_done_o), 64'd1);
    check("b_err",  64'(err_o),      64'd0);
    do_reset();

    // C: illegal target, then recovery
    send_byte(8'h05, 1'b1);
    repeat (20) @(negedge clk);
    check("c_err",   64'(err_o), 64'd1);
    check("c_state", 64'(o_dbg_state.parser), 64'(S_TGT));
    check_strobes("c_none");
    exp_q.push_back({15'h0000, 32'hA5A5_0001});
    seg_begin(8'h80, 16'd1);
    put_word(32'hA5A5_0001);
    seg_end();
    check_strobes("c_strobe");
    check("c_done", 64'(upg_done_o), 64'd1);
    do_reset();

    // D: word count above the limit
    send_byte(8'h80, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (20) @(negedge clk);
    check("d_err",   64'(err_o), 64'd1);
    check("d_state", 64'(o_dbg_state.parser), 64'(S_TGT));
    check("d_done",  64'(upg_done_o), 64'd0);
    check_strobes("d_none");
    do_reset();

    // E: framing error
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("f_err",   64'(err_o), 64'd1);
    check("f_state", 64'(o_dbg_state.parser), 64'(S_TGT));
    do_reset();

    // F: timeout mid-word, then a fresh segment restarts at index 0
    seg_begin(8'h80, 16'd1);
    put_byte(8'hAA);
    put_byte(8'hBB);
    repeat (10) @(negedge clk);
    check("t_no_err_yet", 64'(err_o), 64'd0);
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    check("t_err",   64'(err_o), 64'd1);
    check("t_state", 64'(o_dbg_state.parser), 64'(S_TGT));
    check_strobes("t_none");
    exp_q.push_back({15'h0000, 32'h01020304});
    seg_begin(8'h80, 16'd1);
    put_word(32'h01020304);
    seg_end();
    check_strobes("t_strobe");
    check("t_done", 64'(upg_done_o), 64'd1);
    do_reset();

`ifdef UPG_CHECKSUM_EN
    // G: bad checksum still writes but withholds done; correct one completes
    exp_q.push_back({15'h0000, 32'h00000001});
    send_byte(8'h80, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (40) @(negedge clk);
    check_strobes("cs_bad_strobe");
    check("cs_bad_err",  64'(err_o),      64'd1);
    check("cs_bad_done", 64'(upg_done_o), 64'd0);
    exp_q.push_back({15'h0000, 32'h00000001});
    send_byte(8'h80, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h7E, 1'b1);
    repeat (40) @(negedge clk);
    check_strobes("cs_ok_strobe");
    check("cs_ok_done", 64'(upg_done_o), 64'd1);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
